dds_multi_loader: RTL
=====================

// Module: dds_multi_loader
// PURPOSE
//  Parametrised successor to the single-channel DDS word loader.
//  - Drives NUM_CH AD9850-class DDS chips over a shared 8-bit data bus with per-channel w_clk/fq_ud.
//  - Supports parallel (5 bytes) and serial (40 bits on data[7]) load modes.
//  - Double-buffers the 40-bit tuning words.
//  - Issues one simultaneous fq_ud to every selected channel, so the channels update phase-coherently.
//  - Sits between the pulse-sequencer register file and the DDS pins.
// PARAMETERS
//  NUM_CH   2   number of DDS chips (1..8)
//  CLK_DIV  2   clk_sys cycles per w_clk/fq_ud half-period (>=1)
//  RST_CYC  8   clk_sys cycles dds_reset is held high during init (>=5)
// PORTS
//  clk_sys     in   1        system clock; all logic on its rising edge
//  rst         in   1        asynchronous, active-high reset
//  dds_load    in   1        1-cycle strobe: write dds_para into shadow[dds_ch][dds_field]
//  dds_ch      in   3        target channel (values >= NUM_CH ignored)
//  dds_field   in   2        0=FTW[15:0] 1=FTW[31:16] 2=ctrl byte (dds_para[7:0]) 3=ignored
//  dds_para    in   16       write data
//  ch_mask     in   NUM_CH   channels to load; sampled on state_start
//  ser_mode    in   1        1=serial, 0=parallel; sampled on state_start
//  state_start in   1        1-cycle strobe: begin transfer
//  busy        out  1        transfer or init in progress
//  done        out  1        1-cycle pulse when the fq_ud sequence completes
//  dds_reset   out  1        DDS master reset (shared by all chips)
//  w_clk       out  NUM_CH   per-channel word-load clock
//  fq_ud       out  NUM_CH   per-channel frequency-update strobe
//  data        out  8        shared DDS data bus
// BEHAVIOUR
//  - Reset values: all outputs 0; shadow and active words 0; chip mode = parallel.
//  - On rst release the FSM runs INIT: dds_reset=1 for RST_CYC cycles, busy=1 throughout, then IDLE.
//  - Word format: W = {ctrl[7:0], FTW[31:0]}.
//    - Parallel: bytes sent ctrl first, then FTW[31:24], [23:16], [15:8], [7:0].
//    - Serial: 40 bits LSB first (FTW[0] first, ctrl[7] last) on data[7]; data[6:0]=0.
//  - dds_load is accepted in every state. It writes the shadow only; a transfer uses the active copy taken at start.
//  - state_start is honoured only in IDLE with busy=0, and ignored otherwise.
//    - On acceptance: shadow->active for masked channels; ch_mask and ser_mode are latched; busy=1 from the next cycle.
//  - Mode change: if the latched ser_mode differs from the chip mode, run MODE before loading:
//    - entering parallel: dds_reset pulse of RST_CYC cycles;
//    - entering serial: dds_reset pulse, then one w_clk pulse to all channels with data=8'h03, then one fq_ud pulse to all channels;
//    - each pulse is CLK_DIV high with CLK_DIV low before it.
//  - States: INIT -> IDLE -> [MODE] -> SETUP -> WHI -> (next strobe: SETUP | next channel: SETUP | last: FQUD) -> DONE -> IDLE.
//  - Strobe cycle: SETUP drives data for CLK_DIV cycles with w_clk low; WHI raises w_clk[ch] for CLK_DIV cycles, data held stable.
//  - Strobes per channel: 5 (parallel) or 40 (serial). Channels are loaded in ascending index order; unmasked channels are skipped.
//  - FQUD: fq_ud[i]=1 simultaneously for all masked i, for CLK_DIV cycles.
//  - DONE: done=1 for one cycle with busy=0 that same cycle; the next cycle is IDLE.
//  - Latency, parallel, one channel, no mode change, start at cycle 0:
//    - strobe k: low at 1+2kC..2kC+C, high at 1+(2k+1)C..(2k+2)C (C=CLK_DIV);
//    - fq_ud occupies the next C cycles; done follows on the next cycle (23 for C=2).
//  - ch_mask==0 on accept: no pin activity and no mode change; done pulses 1 cycle after start.
//  - Async rst mid-transfer: all outputs 0 immediately; shadows cleared; INIT reruns; no done is generated.
//  - data returns to 0 in FQUD, DONE and IDLE.
// TESTING
//  - rst 1->0: dds_reset high exactly 8 cycles, busy high for those 8 cycles, then busy=0 in IDLE; w_clk and fq_ud stay 0.
//  - Parallel ch0: load FTW=32'h12345678, ctrl=8'h00, mask=2'b01, start -> bytes 00,12,34,56,78 sampled at w_clk[0] rising edges; fq_ud[0] high cycles 21-22; done at cycle 23.
//  - Dual channel: ch0 FTW=32'h00000001, ch1 FTW=32'h80000000, mask=2'b11 -> ch0 bytes then ch1 bytes; fq_ud=2'b11 asserted in the same cycles; w_clk[1] is never high while w_clk[0] is high.
//  - Serial: ser_mode=1 with FTW=32'h00000005 -> MODE sequence runs (data=8'h03 strobe, then fq_ud), then 40 bits on data[7]: 1,0,1,0...0; the second start in serial has no MODE sequence.
//  - Hazards: dds_load during busy (ch0 FTW lo=16'hFFFF) does not change bytes in flight, and the next start sends the new value; state_start during busy is ignored; mask=0 gives done 1 cycle after start with no pin activity.
//  - rst asserted during the 3rd byte -> all outputs 0 in the same cycle; INIT reruns; shadow reads back 0 on the next transfer.

Source files
------------

// File: rtl/dds_multi_loader.sv
// dds_multi_loader
// Loads 40-bit tuning words into NUM_CH AD9850-class DDS chips that share one
// 8-bit data bus, then updates every loaded chip with one common fq_ud pulse so
// the chips change frequency phase-coherently. Words are written into per-channel
// shadow registers at any time. Each transfer works from an active copy taken
// when the transfer is accepted.
//
// Ports
//   clk_sys      system clock, rising edge
//   rst          asynchronous active-high reset
//   dds_load     strobe: write dds_para into shadow[dds_ch][dds_field]
//   dds_ch       target channel for dds_load (values >= NUM_CH are ignored)
//   dds_field    0 = FTW[15:0], 1 = FTW[31:16], 2 = ctrl byte, 3 = ignored
//   dds_para     write data for dds_load
//   ch_mask      channels to load, sampled when a start is accepted
//   ser_mode     1 = serial load, 0 = parallel load, sampled on accept
//   state_start  strobe: begin a transfer (honoured only when idle)
//   busy         init or transfer in progress
//   done         one-cycle pulse at the end of a transfer
//   dds_reset    master reset shared by all chips
//   w_clk        per-channel word-load clock
//   fq_ud        per-channel frequency-update strobe
//   data         shared data bus (serial data on data[7])
module dds_multi_loader #(
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 2,
  parameter int RST_CYC = 8
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              dds_load,
  input  logic [2:0]        dds_ch,
  input  logic [1:0]        dds_field,
  input  logic [15:0]       dds_para,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              ser_mode,
  input  logic              state_start,
  output logic              busy,
  output logic              done,
  output logic              dds_reset,
  output logic [NUM_CH-1:0] w_clk,
  output logic [NUM_CH-1:0] fq_ud,
  output logic [7:0]        data
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
  // INIT also spends the cycle straight after reset release in the state, with
  // outputs still at their reset values, so it ends one count later.
  localparam logic [15:0] INIT_END = 16'(RST_CYC);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_IDLE     = 4'd1,
    ST_MODE_RLO = 4'd2,
    ST_MODE_RHI = 4'd3,
    ST_MODE_WLO = 4'd4,
    ST_MODE_WHI = 4'd5,
    ST_MODE_FLO = 4'd6,
    ST_MODE_FHI = 4'd7,
    ST_SETUP    = 4'd8,
    ST_WHI      = 4'd9,
    ST_FQUD     = 4'd10,
    ST_DONE     = 4'd11
  } state_t;

  state_t            state_r, state_s;
  logic [15:0]       cnt_r, cnt_s;
  logic [2:0]        ch_r, ch_s;
  logic [5:0]        stb_r, stb_s;
  logic [NUM_CH-1:0] mask_r, mask_s;
  logic              ser_r, ser_s;
  logic              chip_ser_r, chip_ser_s;
  logic              accept_s;

  logic [31:0] shadow_ftw_r  [NUM_CH];
  logic [7:0]  shadow_ctrl_r [NUM_CH];
  logic [31:0] active_ftw_r  [NUM_CH];
  logic [7:0]  active_ctrl_r [NUM_CH];
  logic [31:0] act_ftw_s     [NUM_CH];
  logic [7:0]  act_ctrl_s    [NUM_CH];

  logic [3:0]        first_in_s;
  logic [3:0]        next_lat_s;
  logic [5:0]        stb_last_s;
  logic [39:0]       word_s;
  logic [39:0]       shl_s;
  logic [7:0]        par_byte_s;
  logic              ser_bit_s;
  logic [NUM_CH-1:0] onehot_s;

  logic              busy_s;
  logic              done_s;
  logic              dds_reset_s;
  logic [NUM_CH-1:0] w_clk_s;
  logic [NUM_CH-1:0] fq_ud_s;
  logic [7:0]        data_s;

  // Lowest masked channel index >= start; bit 3 flags that one was found.
  function automatic logic [3:0] find_ch(input logic [NUM_CH-1:0] mask,
                                         input logic [3:0] start);
    logic [3:0] res;
    res = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      res = (mask[i] && (4'(i) >= start)) ? {1'b1, 3'(i)} : res;
    end
    return res;
  endfunction

  assign first_in_s = find_ch(ch_mask, 4'd0);
  assign next_lat_s = find_ch(mask_r, {1'b0, ch_r} + 4'd1);
  assign stb_last_s = ser_r ? 6'd39 : 6'd4;

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ch_s       = ch_r;
    stb_s      = stb_r;
    mask_s     = mask_r;
    ser_s      = ser_r;
    chip_ser_s = chip_ser_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == INIT_END) begin
          state_s = ST_IDLE;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_IDLE: begin
        if (state_start) begin
          accept_s = 1'b1;
          mask_s   = ch_mask;
          ser_s    = ser_mode;
          cnt_s    = 16'd0;
          stb_s    = 6'd0;
          ch_s     = first_in_s[2:0];
          // An empty mask finishes at once and leaves the chip mode alone.
          if (!first_in_s[3]) begin
            state_s = ST_DONE;
          end else if (ser_mode != chip_ser_r) begin
            state_s = ST_MODE_RLO;
          end else begin
            state_s = ST_SETUP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MODE_RLO: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_MODE_RHI;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_MODE_RHI: begin
        if (cnt_r == RST_LAST) begin
          cnt_s = 16'd0;
          // After a reset the chips are in parallel mode; serial needs the
          // 0x03 word plus an update to switch over.
          if (ser_r) begin
            state_s = ST_MODE_WLO;
          end else begin
            chip_ser_s = 1'b0;
            state_s    = ST_SETUP;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_MODE_WLO: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_MODE_WHI;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_MODE_WHI: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_MODE_FLO;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_MODE_FLO: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_MODE_FHI;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_MODE_FHI: begin
        if (cnt_r == DIV_LAST) begin
          chip_ser_s = 1'b1;
          state_s    = ST_SETUP;
          cnt_s      = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_SETUP: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_WHI;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_WHI: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s = 16'd0;
          if (stb_r != stb_last_s) begin
            stb_s   = stb_r + 6'd1;
            state_s = ST_SETUP;
          end else if (next_lat_s[3]) begin
            ch_s    = next_lat_s[2:0];
            stb_s   = 6'd0;
            state_s = ST_SETUP;
          end else begin
            state_s = ST_FQUD;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_FQUD: begin
        if (cnt_r == DIV_LAST) begin
          state_s = ST_DONE;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 16'd0;
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // Active copy as it will be after this edge, so the first strobe of a
  // transfer already drives the freshly captured word.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      act_ftw_s[i]  = (accept_s && ch_mask[i]) ? shadow_ftw_r[i]  : active_ftw_r[i];
      act_ctrl_s[i] = (accept_s && ch_mask[i]) ? shadow_ctrl_r[i] : active_ctrl_r[i];
    end
  end

  // Word, byte and bit currently due on the bus, plus the channel one-hot.
  always_comb begin
    word_s   = 40'd0;
    onehot_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      word_s      = (ch_s == 3'(i)) ? {act_ctrl_s[i], act_ftw_s[i]} : word_s;
      onehot_s[i] = (ch_s == 3'(i));
    end
    // Parallel sends the top byte (ctrl) first; serial sends bit 0 first.
    shl_s      = word_s << {stb_s, 3'b000};
    par_byte_s = shl_s[39:32];
    ser_bit_s  = word_s[stb_s];
  end

  // Pin values for the state being entered; registered below.
  always_comb begin
    busy_s      = 1'b1;
    done_s      = 1'b0;
    dds_reset_s = 1'b0;
    w_clk_s     = {NUM_CH{1'b0}};
    fq_ud_s     = {NUM_CH{1'b0}};
    data_s      = 8'd0;
    case (state_s)
      ST_INIT:     dds_reset_s = 1'b1;
      ST_IDLE:     busy_s = 1'b0;
      ST_MODE_RLO: dds_reset_s = 1'b0;
      ST_MODE_RHI: dds_reset_s = 1'b1;
      ST_MODE_WLO: data_s = 8'h03;
      ST_MODE_WHI: begin
        data_s  = 8'h03;
        w_clk_s = {NUM_CH{1'b1}};
      end
      ST_MODE_FLO: data_s = 8'd0;
      ST_MODE_FHI: fq_ud_s = {NUM_CH{1'b1}};
      ST_SETUP:    data_s = ser_s ? {ser_bit_s, 7'd0} : par_byte_s;
      ST_WHI: begin
        data_s  = ser_s ? {ser_bit_s, 7'd0} : par_byte_s;
        w_clk_s = onehot_s;
      end
      ST_FQUD:     fq_ud_s = mask_s;
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default:     busy_s = 1'b0;
    endcase
  end

  // FSM state, counters and latched transfer settings.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_r    <= ST_INIT;
      cnt_r      <= 16'd0;
      ch_r       <= 3'd0;
      stb_r      <= 6'd0;
      mask_r     <= {NUM_CH{1'b0}};
      ser_r      <= 1'b0;
      chip_ser_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      ch_r       <= ch_s;
      stb_r      <= stb_s;
      mask_r     <= mask_s;
      ser_r      <= ser_s;
      chip_ser_r <= chip_ser_s;
    end
  end

  // Shadow words, writable in every state.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_ftw_r[i]  <= 32'd0;
        shadow_ctrl_r[i] <= 8'd0;
      end
    end else if (dds_load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (dds_ch == 3'(i)) begin
          case (dds_field)
            2'd0:    shadow_ftw_r[i][15:0]  <= dds_para;
            2'd1:    shadow_ftw_r[i][31:16] <= dds_para;
            2'd2:    shadow_ctrl_r[i]       <= dds_para[7:0];
            default: shadow_ctrl_r[i]       <= shadow_ctrl_r[i];
          endcase
        end
      end
    end
  end

  // Active words used by the transfer in flight.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_ftw_r[i]  <= 32'd0;
        active_ctrl_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_ftw_r[i]  <= act_ftw_s[i];
        active_ctrl_r[i] <= act_ctrl_s[i];
      end
    end
  end

  // Output pin registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dds_reset <= 1'b0;
      w_clk     <= {NUM_CH{1'b0}};
      fq_ud     <= {NUM_CH{1'b0}};
      data      <= 8'd0;
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      dds_reset <= dds_reset_s;
      w_clk     <= w_clk_s;
      fq_ud     <= fq_ud_s;
      data      <= data_s;
    end
  end

endmodule
